// File: rtl/down_counter_seq_pkg.sv
// ============================================================================
// Module      : down_counter_seq_pkg
// Description : State encodings and default width for down_counter_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package down_counter_seq_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_FINISH = 2'b10;

endpackage : down_counter_seq_pkg

`default_nettype wire

// File: rtl/down_counter_seq_flipflop.sv
// ============================================================================
// Module      : down_counter_seq_flipflop
// Description : Single D flip-flop with asynchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_counter_seq_flipflop (
    input  logic clk,
    input  logic n_rst,
    input  logic d_i,
    output logic q_o
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q_o <= 1'b0;
        end else begin
            q_o <= d_i;
        end
    end

endmodule : down_counter_seq_flipflop

`default_nettype wire

// File: rtl/down_counter_seq.sv
// ============================================================================
// Module      : down_counter_seq
// Description : Loadable, stallable down-counter sequencer with done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_counter_seq
    import down_counter_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] init_val,
    input  logic             step_en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic [WIDTH:0]   w_borrow;
    logic [WIDTH-1:0] w_dec;
    logic             w_zero;
    logic             w_upper_zero;
    logic             w_is_one;
    logic             w_idle;
    logic             w_run;
    logic             w_finish;
    logic             w_accept;
    logic             w_final;
    logic             w_init_zero;
    logic             w_step;

    // Borrow chain: bit i toggles when all lower bits are zero; the chain
    // output doubles as the zero detect of the current count.
    assign w_borrow[0] = 1'b1;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_borrow
        assign w_borrow[gi+1] = w_borrow[gi] & ~count_q[gi];
        assign w_dec[gi]      = count_q[gi] ^ w_borrow[gi];
    end

    assign w_zero       = w_borrow[WIDTH];
    assign w_upper_zero = ((count_q >> 1) == '0);
    assign w_is_one     = count_q[0] & w_upper_zero;

    assign w_idle      = (state_q == ST_IDLE);
    assign w_run       = (state_q == ST_RUN);
    assign w_finish    = (state_q == ST_FINISH);
    assign w_init_zero = (init_val == '0);

    // FINISH accepts a new job exactly like IDLE so back-to-back runs have no bubble.
    assign w_accept = start & ~abort & (w_idle | w_finish);
    assign w_step   = w_run & step_en & ~abort & ~w_zero;
    assign w_final  = w_step & w_is_one;

    assign state_d = abort    ? ST_IDLE :
                     w_accept ? (w_init_zero ? ST_FINISH : ST_RUN) :
                     w_run    ? (w_final ? ST_FINISH : ST_RUN) :
                                ST_IDLE;

    assign count_d = abort    ? '0 :
                     w_accept ? init_val :
                     w_step   ? w_dec :
                                count_q;

    assign busy_d = (state_d == ST_RUN);
    assign done_d = (state_d == ST_FINISH);

    for (genvar gs = 0; gs < 2; gs++) begin : g_state_ff
        down_counter_seq_flipflop u_ff (
            .clk   (clk),
            .n_rst (n_rst),
            .d_i   (state_d[gs]),
            .q_o   (state_q[gs])
        );
    end

    for (genvar gc = 0; gc < WIDTH; gc++) begin : g_count_ff
        down_counter_seq_flipflop u_ff (
            .clk   (clk),
            .n_rst (n_rst),
            .d_i   (count_d[gc]),
            .q_o   (count_q[gc])
        );
    end

    down_counter_seq_flipflop u_busy_ff (
        .clk   (clk),
        .n_rst (n_rst),
        .d_i   (busy_d),
        .q_o   (busy_q)
    );

    down_counter_seq_flipflop u_done_ff (
        .clk   (clk),
        .n_rst (n_rst),
        .d_i   (done_d),
        .q_o   (done_q)
    );

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign last  = busy_q & w_is_one;

endmodule : down_counter_seq

`default_nettype wire

// File: tb/tb_down_counter_seq.sv
// ============================================================================
// Module      : tb_down_counter_seq
// Description : Self-checking bench for down_counter_seq against a job model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_down_counter_seq;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic [3:0] init_val;
    logic       step_en;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       last;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    // Job-level reference: remaining iterations, whether a job is active,
    // and whether a completion is being reported this cycle.
    int m_count;
    bit m_busy;
    bit m_done;

    down_counter_seq #(.WIDTH(4)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .init_val (init_val),
        .step_en  (step_en),
        .abort    (abort),
        .count    (count),
        .busy     (busy),
        .last     (last),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic model_edge();
        if (!n_rst) begin
            model_reset();
        end else if (abort) begin
            model_reset();
        end else if (start && !m_busy) begin
            m_count = int'(init_val);
            m_busy  = (init_val != 0);
            m_done  = (init_val == 0);
        end else if (m_busy && step_en) begin
            m_count = m_count - 1;
            m_done  = (m_count == 0);
            if (m_count == 0) m_busy = 1'b0;
        end else begin
            m_done = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".count"}, 32'(count), m_count);
        check({tag, ".busy"},  32'(busy),  32'(m_busy));
        check({tag, ".done"},  32'(done),  32'(m_done));
        check({tag, ".last"},  32'(last),  32'(m_busy && m_count == 1));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic wait_done(input string tag, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle(tag);
            lat++;
            if (done) seen = 1'b1;
        end
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int lat;
        int pulses;

        n_rst    = 1'b0;
        start    = 1'b0;
        init_val = 4'd0;
        step_en  = 1'b0;
        abort    = 1'b0;
        model_reset();
        #2;
        check_outputs("reset");
        cycle("reset_hold");
        n_rst = 1'b1;
        cycle("idle");

        // Asynchronous reset in the middle of a run at count=5
        start = 1'b1; init_val = 4'd8; step_en = 1'b1;
        cycle("s1_load");
        start = 1'b0;
        repeat (3) cycle("s1_run");
        check("s1_pre_count", 32'(count), 32'd5);
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        check_outputs("s1_async");
        cycle("s1_hold");
        n_rst = 1'b1;
        cycle("s1_idle");

        // Plain run of 4
        start = 1'b1; init_val = 4'd4; step_en = 1'b1;
        cycle("s2_load");
        start = 1'b0;
        wait_done("s2", lat);
        check("s2_latency", 32'(lat), 32'd4);
        cycle("s2_after");

        // Run of 6 with two stall cycles at count=3
        start = 1'b1; init_val = 4'd6;
        cycle("s3_load");
        start = 1'b0;
        repeat (3) cycle("s3_run");
        check("s3_at3", 32'(count), 32'd3);
        step_en = 1'b0;
        repeat (2) cycle("s3_stall");
        check("s3_held", 32'(count), 32'd3);
        step_en = 1'b1;
        wait_done("s3", lat);
        check("s3_latency", 32'(3 + 2 + lat), 32'd8);
        cycle("s3_after");

        // Zero iteration count
        start = 1'b1; init_val = 4'd0;
        cycle("s4_load");
        start = 1'b0;
        check("s4_done", 32'(done), 32'd1);
        check("s4_busy", 32'(busy), 32'd0);
        cycle("s4_after");

        // start ignored in RUN, accepted in FINISH
        pulses = 0;
        start = 1'b1; init_val = 4'd5;
        cycle("s5_load");
        start = 1'b0;
        repeat (3) cycle("s5_run");
        start = 1'b1; init_val = 4'd9;
        cycle("s5_ignored");
        check("s5_ign_count", 32'(count), 32'd1);
        start = 1'b0;
        cycle("s5_first_done");
        if (done) pulses++;
        start = 1'b1; init_val = 4'd3;
        cycle("s5_reload");
        check("s5_no_bubble", 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle("s5_run2");
            if (done) pulses++;
        end
        check("s5_pulses", 32'(pulses), 32'd2);

        // abort wins over final decrement and start
        start = 1'b1; init_val = 4'd3;
        cycle("s6_load");
        start = 1'b0;
        repeat (2) cycle("s6_run");
        check("s6_at1", 32'(count), 32'd1);
        abort = 1'b1; step_en = 1'b1; start = 1'b1; init_val = 4'd7;
        cycle("s6_abort");
        abort = 1'b0; start = 1'b0;
        cycle("s6_after");
        check("s6_no_done", 32'(done), 32'd0);

        // Full range without wrap
        start = 1'b1; init_val = 4'd15;
        cycle("s6_full_load");
        start = 1'b0;
        wait_done("s6_full", lat);
        check("s6_full_latency", 32'(lat), 32'd15);
        repeat (3) cycle("s6_nowrap");

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom % 4) == 0;
            init_val = 4'($urandom % 16);
            step_en  = ($urandom % 4) != 0;
            abort    = ($urandom % 32) == 0;
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_down_counter_seq

`default_nettype wire
